// File: rtl/fe_fifo_read_arb_pkg.sv
// Shared front-end FIFO defines plus the read-arbiter state and grant types.
// The optional statistics counters are enabled with FE_FIFO_ARB_STATS_EN.
`ifndef FE_FIFO_ENTRY_WIDTH
`define FE_FIFO_ENTRY_WIDTH 18
`endif
`ifndef FE_FIFO_CMD_START
`define FE_FIFO_CMD_START 16
`endif
`ifndef FE_FIFO_CMD_BIT_LEN
`define FE_FIFO_CMD_BIT_LEN 2
`endif

`define FE_ARB_S_IDLE  3'd0
`define FE_ARB_S_FETCH 3'd1
`define FE_ARB_S_LOAD  3'd2
`define FE_ARB_S_B0    3'd3
`define FE_ARB_S_B1    3'd4
`define FE_ARB_S_B2    3'd5

package fe_fifo_read_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = `FE_ARB_S_IDLE,
        S_FETCH = `FE_ARB_S_FETCH,
        S_LOAD  = `FE_ARB_S_LOAD,
        S_B0    = `FE_ARB_S_B0,
        S_B1    = `FE_ARB_S_B1,
        S_B2    = `FE_ARB_S_B2
    } arb_state_e;

    typedef enum logic {
        GNT_REG    = 1'b0,
        GNT_STREAM = 1'b1
    } grant_e;

endpackage

// File: rtl/fe_fifo_read_arb_if.sv
// Bundle of FIFO read-side and USB requester signals around fe_fifo_read_arb.
interface fe_fifo_read_arb_if #(
    parameter int pENTRY_WIDTH = 18,
    parameter int pSTAT_WIDTH  = 16
);
    logic [pENTRY_WIDTH-1:0] I_fifo_dout;
    logic                    I_fifo_empty;
    logic                    I_fifo_flush;
    logic                    O_fifo_rd;
    logic                    I_reg_req;
    logic                    I_stream_req;
    logic [7:0]              O_data;
    logic                    O_reg_valid;
    logic                    O_stream_valid;
    logic                    O_busy;
    logic [pSTAT_WIDTH-1:0]  O_reg_entries;
    logic [pSTAT_WIDTH-1:0]  O_stream_entries;

    modport master (
        input  I_fifo_dout, I_fifo_empty, I_fifo_flush, I_reg_req, I_stream_req,
        output O_fifo_rd, O_data, O_reg_valid, O_stream_valid, O_busy,
               O_reg_entries, O_stream_entries
    );

    modport slave (
        output I_fifo_dout, I_fifo_empty, I_fifo_flush, I_reg_req, I_stream_req,
        input  O_fifo_rd, O_data, O_reg_valid, O_stream_valid, O_busy,
               O_reg_entries, O_stream_entries
    );
endinterface

// File: rtl/fe_fifo_read_arb_rr_arb2.sv
// Two-way round-robin arbiter: grant is latched on lock and held for the entry.
module rr_arb2
    import fe_fifo_read_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_reg,
    input  logic   req_stream,
    input  logic   lock,
    input  logic   done,
    output grant_e gnt
);
    grant_e last_grant;
    grant_e eff_last;
    grant_e decision;

    // A back-to-back decision at entry completion must see the entry just finished.
    always_comb begin
        eff_last = done ? gnt : last_grant;
        decision = gnt;
        if (req_reg && !req_stream)
            decision = GNT_REG;
        else if (req_stream && !req_reg)
            decision = GNT_STREAM;
        else if (req_reg && req_stream)
            decision = (eff_last == GNT_STREAM) ? GNT_REG : GNT_STREAM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= GNT_REG;
            last_grant <= GNT_STREAM;
        end else begin
            if (lock)
                gnt <= decision;
            if (done)
                last_grant <= gnt;
        end
    end
endmodule

// File: rtl/fe_fifo_read_arb.sv
// Shares the capture FIFO read port between register and stream paths, three bytes per entry.
// Optional per-requester entry counters are built with FE_FIFO_ARB_STATS_EN.
module fe_fifo_read_arb
    import fe_fifo_read_arb_pkg::*;
#(
    parameter int pENTRY_WIDTH = `FE_FIFO_ENTRY_WIDTH,
    parameter int pSTAT_WIDTH  = 16
)(
    input logic                cwusb_clk,
    input logic                reset_i,
    fe_fifo_read_arb_if.master bus
);
    arb_state_e state;
    arb_state_e next_state;
    grant_e     gnt;
    logic       lock;
    logic       done;
    logic       accept;
    logic       can_start;
    logic       granted_req;
    logic [pENTRY_WIDTH-`FE_FIFO_CMD_BIT_LEN-1:0] hold;

    rr_arb2 u_rr_arb2 (
        .clk        (cwusb_clk),
        .rst        (reset_i),
        .req_reg    (bus.I_reg_req),
        .req_stream (bus.I_stream_req),
        .lock       (lock),
        .done       (done),
        .gnt        (gnt)
    );

    always_comb begin
        granted_req = (gnt == GNT_STREAM) ? bus.I_stream_req : bus.I_reg_req;
        accept      = (state inside {S_B0, S_B1, S_B2}) && granted_req;
        can_start   = (bus.I_reg_req || bus.I_stream_req) && !bus.I_fifo_empty && !bus.I_fifo_flush;
        next_state  = state;
        lock        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE:  if (can_start) begin
                         next_state = S_FETCH;
                         lock       = 1'b1;
                     end
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_B0;
            S_B0:    if (accept) next_state = S_B1;
            S_B1:    if (accept) next_state = S_B2;
            S_B2:    if (accept) begin
                         done = 1'b1;
                         if (can_start) begin
                             next_state = S_FETCH;
                             lock       = 1'b1;
                         end else begin
                             next_state = S_IDLE;
                         end
                     end
            default: next_state = S_IDLE;
        endcase
        // Flush abandons whatever entry is in flight.
        if (bus.I_fifo_flush) begin
            next_state = S_IDLE;
            lock       = 1'b0;
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset_i)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            bus.O_fifo_rd      <= 1'b0;
            bus.O_data         <= 8'd0;
            bus.O_reg_valid    <= 1'b0;
            bus.O_stream_valid <= 1'b0;
            bus.O_busy         <= 1'b0;
            hold               <= '0;
        end else begin
            bus.O_fifo_rd      <= (next_state == S_FETCH);
            bus.O_busy         <= (next_state != S_IDLE);
            bus.O_reg_valid    <= (next_state inside {S_B0, S_B1, S_B2}) && (gnt == GNT_REG);
            bus.O_stream_valid <= (next_state inside {S_B0, S_B1, S_B2}) && (gnt == GNT_STREAM);
            if (state == S_LOAD && next_state == S_B0) begin
                hold       <= bus.I_fifo_dout[pENTRY_WIDTH-`FE_FIFO_CMD_BIT_LEN-1:0];
                bus.O_data <= {{(8-`FE_FIFO_CMD_BIT_LEN){1'b0}},
                               bus.I_fifo_dout[`FE_FIFO_CMD_START +: `FE_FIFO_CMD_BIT_LEN]};
            end else if (state == S_B0 && next_state == S_B1) begin
                bus.O_data <= hold[15:8];
            end else if (state == S_B1 && next_state == S_B2) begin
                bus.O_data <= hold[7:0];
            end
        end
    end

`ifdef FE_FIFO_ARB_STATS_EN
    logic [pSTAT_WIDTH-1:0] reg_cnt;
    logic [pSTAT_WIDTH-1:0] stream_cnt;

    always_ff @(posedge cwusb_clk) begin
        if (reset_i || bus.I_fifo_flush) begin
            reg_cnt    <= '0;
            stream_cnt <= '0;
        end else if (done) begin
            if (gnt == GNT_REG && reg_cnt != '1)
                reg_cnt <= reg_cnt + pSTAT_WIDTH'(1);
            if (gnt == GNT_STREAM && stream_cnt != '1)
                stream_cnt <= stream_cnt + pSTAT_WIDTH'(1);
        end
    end

    assign bus.O_reg_entries    = reg_cnt;
    assign bus.O_stream_entries = stream_cnt;
`else
    assign bus.O_reg_entries    = {pSTAT_WIDTH{1'b0}};
    assign bus.O_stream_entries = {pSTAT_WIDTH{1'b0}};
`endif
endmodule
